// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time, presents
// instructions to decode, and applies redirects. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] fetch_count,
  output logic        misaligned_err
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] if_pc_n, if_instr_n, fetch_count_n;
  logic        err_n;

  logic        redir;
  logic        bad_target;
  logic [31:0] target;

  // Redirects only act once the sequencer is live; BOOT and HALT ignore them.
  assign redir = redirect_valid && (state != BOOT) && (state != HALT);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_target = (redirect_pc[1:0] != 2'b00);
  assign target     = redirect_pc;
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_pc[1:0];
  assign bad_target = 1'b0;
  assign target     = {redirect_pc[31:2], 2'b00};
`endif

  // Both handshake outputs decode the state register only, so no input reaches them.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == HOLD);

  always_comb begin
    // NOTE: every next-value starts as "hold", so no path through the case leaves a latch.
    state_n       = state;
    pc_n          = pc;
    req_pc_n      = req_pc;
    if_pc_n       = if_pc;
    if_instr_n    = if_instr;
    fetch_count_n = fetch_count;
    err_n         = misaligned_err;

    case (state)
      BOOT: state_n = REQ;

      REQ: begin
        if (imem_req_ready) begin
          req_pc_n = pc;
          state_n  = WAIT;
        end
        if (redir) begin
          if (bad_target) begin
            err_n   = 1'b1;
            state_n = imem_req_ready ? DROP : HALT;
          end else begin
            pc_n    = target;
            state_n = imem_req_ready ? DROP : REQ;
          end
        end
      end

      WAIT: begin
        if (redir) begin
          // A response arriving alongside the redirect is simply not captured.
          if (bad_target) begin
            err_n   = 1'b1;
            state_n = imem_rsp_valid ? HALT : DROP;
          end else begin
            pc_n    = target;
            state_n = imem_rsp_valid ? REQ : DROP;
          end
        end else if (imem_rsp_valid) begin
          if_instr_n = imem_rsp_data;
          if_pc_n    = req_pc;
          pc_n       = req_pc + 32'd4;
          state_n    = HOLD;
        end
      end

      HOLD: begin
        if (redir) begin
          if (bad_target) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            pc_n    = target;
            state_n = REQ;
          end
        end else if (if_ready) begin
          fetch_count_n = fetch_count + 32'd1;
          state_n       = REQ;
        end
      end

      DROP: begin
        if (redir) begin
          if (bad_target) err_n = 1'b1;
          else            pc_n  = target;
        end
        // Once the stale response drains, a recorded misalignment parks the fetcher.
        if (imem_rsp_valid) state_n = err_n ? HALT : REQ;
      end

      HALT: state_n = HALT;

      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
      if_pc          <= 32'd0;
      if_instr       <= 32'd0;
      fetch_count    <= 32'd0;
      misaligned_err <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      req_pc         <= req_pc_n;
      if_pc          <= if_pc_n;
      if_instr       <= if_instr_n;
      fetch_count    <= fetch_count_n;
      misaligned_err <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b1;
  logic [31:0] fetch_count;
  logic        misaligned_err;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .fetch_count    (fetch_count),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory model: sees the handshake on the falling edge before the accepting edge,
  // then returns the word lat+1 rising edges after acceptance.
  int          lat = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'd0;

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend && pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 0;
      end else if (pend) begin
        pend_cnt = pend_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1;
        pend_cnt  = lat;
        pend_addr = imem_req_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max);
    for (int n = 0; n < max && !imem_req_valid; n++) step();
    checks++;
    if (!imem_req_valid) begin
      errors++;
      $display("FAIL wait_req: imem_req_valid=%0b required 1 within %0d cycles", imem_req_valid, max);
    end
  endtask

  task automatic wait_ifv(input int max);
    for (int n = 0; n < max && !if_valid; n++) step();
    checks++;
    if (!if_valid) begin
      errors++;
      $display("FAIL wait_ifv: if_valid=%0b required 1 within %0d cycles", if_valid, max);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1; lat = 0;
    step(); step();
    checks++;
    if ({imem_req_valid, if_valid, misaligned_err} !== 3'b000 || if_pc !== 32'd0 ||
        if_instr !== 32'd0 || fetch_count !== 32'd0 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_values: req=%0b ifv=%0b err=%0b pc=%h instr=%h cnt=%0d addr=%h required 0,0,0,0,0,0,00000100",
               imem_req_valid, if_valid, misaligned_err, if_pc, if_instr, fetch_count, imem_req_addr);
    end
    rst = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle: imem_req_valid=%0b required 0", imem_req_valid);
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL first_req: valid=%0b addr=%h required 1 00000100", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = 32'h100 + 32'(4 * i);
      wait_req(10);
      checks++;
      if (imem_req_addr !== exp) begin
        errors++;
        $display("FAIL seq_addr%0d: addr=%h required %h", i, imem_req_addr, exp);
      end
      wait_ifv(10);
      checks++;
      if (if_pc !== exp || if_instr !== mem_word(exp)) begin
        errors++;
        $display("FAIL seq_if%0d: pc=%h instr=%h required %h %h", i, if_pc, if_instr, exp, mem_word(exp));
      end
    end
    step();
    checks++;
    if (fetch_count !== 32'd3 || imem_req_addr !== 32'h10C) begin
      errors++;
      $display("FAIL seq_count: cnt=%0d addr=%h required 3 0000010c", fetch_count, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    bit saw_ifv;
    lat = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    step();
    redirect_valid = 1'b0; lat = 0;
    n = 0; saw_ifv = 0;
    while (n < 10 && !imem_req_valid) begin
      if (if_valid) saw_ifv = 1;
      step();
      n++;
    end
    checks++;
    if (n != 3 || imem_req_addr !== 32'h2000 || saw_ifv) begin
      errors++;
      $display("FAIL redirect_wait: drain=%0d addr=%h ifv_seen=%0b required 3 00002000 0", n, imem_req_addr, saw_ifv);
    end
    wait_ifv(10);
    checks++;
    if (if_pc !== 32'h2000 || if_instr !== mem_word(32'h2000)) begin
      errors++;
      $display("FAIL redirect_wait_if: pc=%h instr=%h required 00002000 %h", if_pc, if_instr, mem_word(32'h2000));
    end
    // Flush the held word while decode is ready: it must not be counted.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL hold_flush: ifv=%0b req=%0b addr=%h cnt=%0d required 0 1 00000100 3",
               if_valid, imem_req_valid, imem_req_addr, fetch_count);
    end
  endtask

  task automatic test_redirect_with_rsp();
    wait_ifv(10);
    step();
    checks++;
    if (fetch_count !== 32'd4 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
      errors++;
      $display("FAIL rsp_pre: cnt=%0d req=%0b addr=%h required 4 1 00000104", fetch_count, imem_req_valid, imem_req_addr);
    end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400 || if_valid !== 1'b0 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL redirect_rsp: req=%0b addr=%h ifv=%0b cnt=%0d required 1 00000400 0 4",
               imem_req_valid, imem_req_addr, if_valid, fetch_count);
    end
  endtask

  task automatic test_hold_stall();
    if_ready = 1'b0;
    wait_ifv(10);
    checks++;
    if (if_pc !== 32'h400 || if_instr !== mem_word(32'h400)) begin
      errors++;
      $display("FAIL stall_if: pc=%h instr=%h required 00000400 %h", if_pc, if_instr, mem_word(32'h400));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== mem_word(32'h400) || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: ifv=%0b pc=%h instr=%h req=%0b required 1 00000400 %h 0",
                 i, if_valid, if_pc, if_instr, imem_req_valid, mem_word(32'h400));
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0; if_ready = 1'b1;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL stall_redirect: ifv=%0b req=%0b addr=%h cnt=%0d required 0 1 00000080 4",
               if_valid, imem_req_valid, imem_req_addr, fetch_count);
    end
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_req(10);
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: addr=%h required fffffffc", imem_req_addr);
    end
    wait_ifv(10);
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_if: pc=%h instr=%h required fffffffc %h", if_pc, if_instr, mem_word(32'hFFFF_FFFC));
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || fetch_count !== 32'd5) begin
      errors++;
      $display("FAIL wrap_next: req=%0b addr=%h cnt=%0d required 1 00000000 5", imem_req_valid, imem_req_addr, fetch_count);
    end
  endtask

  task automatic test_misaligned();
    bit saw_req;
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    saw_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) saw_req = 1;
      step();
    end
    checks++;
    if (saw_req || misaligned_err !== 1'b1 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_halt: req_seen=%0b err=%0b ifv=%0b required 0 1 0", saw_req, misaligned_err, if_valid);
    end
`else
    saw_req = 0;
    wait_req(10);
    checks++;
    if (imem_req_addr !== 32'h200 || misaligned_err !== 1'b0 || saw_req) begin
      errors++;
      $display("FAIL misalign_force: addr=%h err=%0b required 00000200 0", imem_req_addr, misaligned_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1;
    step(); step();
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || fetch_count !== 32'd0 || misaligned_err !== 1'b0 ||
        if_pc !== 32'd0 || if_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: req=%0b ifv=%0b cnt=%0d err=%0b pc=%h instr=%h required 0 0 0 0 0 0",
               imem_req_valid, if_valid, fetch_count, misaligned_err, if_pc, if_instr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_restart: req=%0b addr=%h required 1 00000100", imem_req_valid, imem_req_addr);
    end
    wait_ifv(10);
    checks++;
    if (if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL reset_refetch: pc=%h instr=%h required 00000100 %h", if_pc, if_instr, mem_word(32'h100));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_hold_stall();
    test_pc_wrap();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
